pipelined_accumulating_adder: RTL and testbench
===============================================

# pipelined_accumulating_adder

Parametrised, pipelined multi-operand adder with optional frame accumulation and saturation. Sums `LANES` unsigned operands per beat through a registered adder tree. It either emits each sum directly or accumulates sums across a frame and emits one total when the frame ends. It sits in the arithmetic datapath as the successor of the single-cycle two-operand adder and adds valid/ready flow control on both sides.

## Interface

**Parameters**
- `WIDTH`, default 8: operand width in bits.
- `LANES`, default 4: operands per beat; must be a power of two and ≥2.
- `ACC_W`, default `WIDTH+$clog2(LANES)+8`: accumulator and output width; must be ≥ `WIDTH+$clog2(LANES)`.

**Ports**
- `clk`, input, 1: single clock; all logic on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: input beat present.
- `in_ready`, output, 1: block accepts a beat this cycle.
- `in_data`, input, `LANES*WIDTH`: lane k is `in_data[k*WIDTH +: WIDTH]`, unsigned.
- `in_last`, input, 1: beat closes the current accumulation frame.
- `acc_mode`, input, 1: 1 means accumulate the beat into the open frame; 0 means the beat is a frame by itself.
- `out_valid`, output, 1: result present.
- `out_ready`, input, 1: downstream accepts the result.
- `out_sum`, output, `ACC_W`: frame total.
- `out_sat`, output, 1: total was clamped during this frame.

## Operation

- **Handshakes**
  - Input transfer happens when `in_valid && in_ready`.
  - Output transfer happens when `out_valid && out_ready`.
  - `in_last` and `acc_mode` are sampled with the beat and travel with it through the pipeline.
- **Adder tree**
  - `$clog2(LANES)` registered levels of pairwise adds; each level is one bit wider than the one before it.
  - Tree result width is `SUM_W = WIDTH+$clog2(LANES)`; it is zero-extended to `ACC_W`.
  - A valid bit accompanies each level, so bubbles propagate unchanged.
- **Final stage**
  - Holds the accumulator `acc` (`ACC_W` bits) and a sticky `sat_f` flag.
  - FSM states: `IDLE` (no open frame, `acc`=0) and `OPEN` (frame in progress).
- **Handling of a beat that arrives at the final stage.** Let `t = acc + sum`, computed at `ACC_W+1` bits. If `t` exceeds `2^ACC_W-1`, `t` is clamped to all-ones and `sat_f` is set.
  - If `acc_mode`=1 and `in_last`=0: `acc<=t`, the FSM goes to `OPEN`, and no output is produced.
  - If `acc_mode`=0, or `in_last`=1: `out_sum<=t`, `out_sat<=sat_f|clamp`, and `out_valid<=1`. Then `acc<=0`, `sat_f<=0`, and the FSM goes to `IDLE`.
  - If `acc_mode` drops to 0 while a frame is `OPEN`: the open partial total is included in that beat's output, and the frame closes.
- **Stall**
  - `in_ready = !(out_valid && !out_ready)`.
  - While stalled, every pipeline level, `acc` and the output register hold their values.
  - No beat is dropped or duplicated, and results leave in acceptance order.
- **Reset**
  - Asserting `rst` low clears all valid bits, `acc`, `sat_f`, `out_sum`, `out_sat` and `out_valid` to 0, and puts the FSM in `IDLE`.
  - Consequently `in_ready` reads 1 while `rst` is low and immediately after release.
  - A frame open at reset is discarded, and the next beat starts a new frame from 0.

## Timing

- Latency is `L = $clog2(LANES)+1` cycles from input acceptance to `out_valid` for a closing beat, when no stall occurs. With the defaults, `L` = 3.
- Throughput is one beat per cycle, sustained while `out_ready`=1.
- `in_ready` is combinational from `out_valid` and `out_ready`; every other output is registered.
- Simultaneous events are handled without bubbles:
  - an output transfer and a new closing result in the same cycle load the next result directly;
  - an input acceptance and an output transfer in the same cycle are both honoured.
- `out_valid` stays high, and `out_sum`/`out_sat` stay stable, until the output transfer happens.

## Structure

- **Shared package `adder_pkg`**
  - Width helper function `sum_w(WIDTH, LANES)`.
  - FSM state enum `acc_state_e` with values `IDLE` and `OPEN`.
  - The saturating-add function.
- **Sub-module `adder_tree_level`**
  - Parametrised by input width and pair count.
  - Contains one registered pairwise-add level with its valid bit, stall enable and asynchronous active-low reset.
  - Instantiated `$clog2(LANES)` times via generate.
- **Top level** contains the final stage, the FSM and the handshake logic.

## Test plan

Defaults throughout (`WIDTH`=8, `LANES`=4, `ACC_W`=18) unless stated otherwise.

1. Single beat {1,2,3,4}, `acc_mode`=0 → `out_sum`=10 and `out_sat`=0, with `out_valid` rising exactly 3 cycles after acceptance.
2. Back-to-back beats {0xFF×4} then {0,0,0,1}, both with `acc_mode`=0, `out_ready`=1 → outputs 1020 then 1, on consecutive cycles.
3. Three beats {10,10,10,10} with `acc_mode`=1 and `in_last` set only on the third → exactly one output, 120, and no `out_valid` for the first two beats.
4. Stream of 8 distinct beats with `out_ready` held low for 5 cycles mid-stream → `in_ready` low during the stall, and all 8 sums delivered in order with none lost.
5. `ACC_W`=10, frame of two {0xFF×4} beats with `acc_mode`=1 → `out_sum`=1023 and `out_sat`=1; the following single beat {1,0,0,0} → 1 with `out_sat`=0.
6. `rst` pulsed low asynchronously after two accumulate beats of an open frame → `out_valid`=0 immediately; after release, a closing beat {2,2,2,2} → `out_sum`=8.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and arithmetic helpers for the pipelined accumulating adder.
// Saturating helpers work on a fixed 64-bit carrier; callers zero-extend and truncate.
package adder_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } acc_state_e;

  function automatic int unsigned sum_w(input int unsigned width, input int unsigned lanes);
    return width + $clog2(lanes);
  endfunction

  // All-ones value of a w-bit field, held in the widened carrier.
  function automatic logic [MAX_W:0] sat_limit(input int unsigned w);
    logic [MAX_W:0] one;
    one = {{MAX_W{1'b0}}, 1'b1};
    return (one << w) - one;
  endfunction

  function automatic logic sat_clamp(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b,
                                     input int unsigned w);
    logic [MAX_W:0] t;
    t = {1'b0, a} + {1'b0, b};
    return t > sat_limit(w);
  endfunction

  function automatic logic [MAX_W:0] sat_add(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b,
                                             input int unsigned w);
    logic [MAX_W:0] t;
    logic [MAX_W:0] lim;
    t   = {1'b0, a} + {1'b0, b};
    lim = sat_limit(w);
    return (t > lim) ? lim : t;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered level of the adder tree: PAIRS pairwise adds, each one bit wider
// than its operands, with a valid bit and a 2-bit sideband that travel alongside.
module adder_tree_level #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned PAIRS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       in_valid,
  input  logic [1:0]                 in_tag,
  input  logic [2*PAIRS*IN_W-1:0]    in_data,
  output logic                       out_valid,
  output logic [1:0]                 out_tag,
  output logic [PAIRS*(IN_W+1)-1:0]  out_data
);

  localparam int unsigned OW = IN_W + 1;

  logic [PAIRS*OW-1:0] sums;

  always_comb begin
    sums = '0;
    for (int unsigned p = 0; p < PAIRS; p++) begin
      sums[p*OW +: OW] = OW'(in_data[2*p*IN_W +: IN_W]) + OW'(in_data[(2*p+1)*IN_W +: IN_W]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_tag   <= in_tag;
      out_data  <= sums;
    end
  end

endmodule

// File: rtl/pipelined_accumulating_adder.sv
// Pipelined LANES-operand adder with optional frame accumulation and saturation,
// valid/ready on both sides; the whole pipeline advances only when the output can move.
module pipelined_accumulating_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 4,
  parameter int unsigned ACC_W = WIDTH + $clog2(LANES) + 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_last,
  input  logic                   acc_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_sum,
  output logic                   out_sat
);

  localparam int unsigned LEVELS = $clog2(LANES);
  localparam int unsigned SUM_W  = sum_w(WIDTH, LANES);

  logic adv;

  assign in_ready = !(out_valid && !out_ready);
  assign adv      = in_ready;

  for (genvar i = 0; i < LEVELS; i++) begin : g_lvl
    localparam int unsigned IW = WIDTH + i;
    localparam int unsigned NP = LANES >> (i + 1);

    logic                 v;
    logic [1:0]           tag;
    logic [NP*(IW+1)-1:0] d;

    if (i == 0) begin : g_head
      adder_tree_level #(.IN_W(IW), .PAIRS(NP)) u_level (
        .clk      (clk),
        .rst      (rst),
        .en       (adv),
        .in_valid (in_valid),
        .in_tag   ({in_last, acc_mode}),
        .in_data  (in_data),
        .out_valid(v),
        .out_tag  (tag),
        .out_data (d)
      );
    end else begin : g_body
      adder_tree_level #(.IN_W(IW), .PAIRS(NP)) u_level (
        .clk      (clk),
        .rst      (rst),
        .en       (adv),
        .in_valid (g_lvl[i-1].v),
        .in_tag   (g_lvl[i-1].tag),
        .in_data  (g_lvl[i-1].d),
        .out_valid(v),
        .out_tag  (tag),
        .out_data (d)
      );
    end
  end

  logic             tail_v;
  logic             tail_last;
  logic             tail_mode;
  logic [SUM_W-1:0] tail_sum;

  assign tail_v                 = g_lvl[LEVELS-1].v;
  assign {tail_last, tail_mode} = g_lvl[LEVELS-1].tag;
  assign tail_sum               = g_lvl[LEVELS-1].d;

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] t_val;
  logic             sat_q, sat_d;
  logic             clamp;
  logic             close_beat;

  // A beat with acc_mode=0 closes any open frame, so the partial total is always the base.
  always_comb begin
    base       = (state_q == OPEN) ? acc_q : '0;
    t_val      = ACC_W'(sat_add(MAX_W'(base), MAX_W'(tail_sum), ACC_W));
    clamp      = sat_clamp(MAX_W'(base), MAX_W'(tail_sum), ACC_W);
    close_beat = 1'b0;
    state_d    = state_q;
    acc_d      = acc_q;
    sat_d      = sat_q;
    if (adv && tail_v) begin
      if (tail_mode && !tail_last) begin
        state_d = OPEN;
        acc_d   = t_val;
        sat_d   = sat_q | clamp;
      end else begin
        close_beat = 1'b1;
        state_d    = IDLE;
        acc_d      = '0;
        sat_d      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      out_valid <= close_beat;
      if (close_beat) begin
        out_sum <= t_val;
        out_sat <= (state_q == OPEN) ? (sat_q | clamp) : clamp;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_accumulating_adder.sv
// Self-checking bench for pipelined_accumulating_adder: vector table, hand-written
// corner sequences, and a randomized stream scored against a frame-level model.
module tb_pipelined_accumulating_adder;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned LANES   = 4;
  localparam int unsigned ACC_W   = 18;
  localparam int unsigned ACC_W_S = 10;
  localparam int          LAT     = 3;
  localparam longint      MAXV    = (longint'(1) << ACC_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               in_valid, in_ready, in_last, acc_mode;
  logic [31:0]        in_data;
  logic               out_valid, out_ready, out_sat;
  logic [ACC_W-1:0]   out_sum;

  logic               b_in_valid, b_in_ready, b_in_last, b_acc_mode;
  logic [31:0]        b_in_data;
  logic               b_out_valid, b_out_ready, b_out_sat;
  logic [ACC_W_S-1:0] b_out_sum;

  pipelined_accumulating_adder #(.WIDTH(WIDTH), .LANES(LANES), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .acc_mode(acc_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_sat(out_sat)
  );

  pipelined_accumulating_adder #(.WIDTH(WIDTH), .LANES(LANES), .ACC_W(ACC_W_S)) dut_s (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_last(b_in_last), .acc_mode(b_acc_mode), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_sat(b_out_sat)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Frame-level reference model
  typedef struct { longint sum; bit sat; } res_t;
  res_t   exp_q[$];
  longint open_sum;
  bit     open_sat;
  bit     mon_en;
  int     n_out;

  function automatic longint lane_total(input logic [31:0] d);
    longint s;
    s = 0;
    for (int k = 0; k < LANES; k++) s += d[k*WIDTH +: WIDTH];
    return s;
  endfunction

  task automatic model_accept(input logic [31:0] d, input logic last, input logic mode);
    longint t;
    bit     clamp;
    res_t   r;
    t     = open_sum + lane_total(d);
    clamp = (t > MAXV);
    if (clamp) t = MAXV;
    if (mode && !last) begin
      open_sum = t;
      open_sat = open_sat | clamp;
    end else begin
      r.sum = t;
      r.sat = open_sat | clamp;
      exp_q.push_back(r);
      open_sum = 0;
      open_sat = 0;
    end
  endtask

  res_t mon_e;
  always @(negedge clk) begin
    #1;
    if (mon_en && rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mon_unexpected: got output sum %0d, required no output", out_sum);
        end else begin
          mon_e = exp_q.pop_front();
          chk("mon_sum", out_sum, mon_e.sum);
          chk("mon_sat", out_sat, mon_e.sat);
          n_out++;
        end
      end
      if (in_valid && in_ready) model_accept(in_data, in_last, acc_mode);
    end
  end

  task automatic collect_a(output int seen, output int lat, output longint s, output bit sat);
    seen = 0; lat = 0; s = 0; sat = 0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      if (out_valid) begin
        seen++;
        if (seen == 1) begin lat = c; s = out_sum; sat = out_sat; end
      end
      @(negedge clk);
    end
  endtask

  task automatic collect_b(output int seen, output int lat, output longint s, output bit sat);
    seen = 0; lat = 0; s = 0; sat = 0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      if (b_out_valid) begin
        seen++;
        if (seen == 1) begin lat = c; s = b_out_sum; sat = b_out_sat; end
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        mode;
    int          nout;
    longint      sum;
    bit          sat;
  } vec_t;

  vec_t        vec[10];
  logic [31:0] sbeat[8];
  int          seen, lat, idx;
  longint      s;
  bit          sat;

  initial begin
    vec[0] = '{32'h04030201, 1'b0, 1'b0, 1, 10,   1'b0};
    vec[1] = '{32'hFFFFFFFF, 1'b0, 1'b0, 1, 1020, 1'b0};
    vec[2] = '{32'h01000000, 1'b0, 1'b0, 1, 1,    1'b0};
    vec[3] = '{32'h0A0A0A0A, 1'b0, 1'b1, 0, 0,    1'b0};
    vec[4] = '{32'h0A0A0A0A, 1'b0, 1'b1, 0, 0,    1'b0};
    vec[5] = '{32'h0A0A0A0A, 1'b1, 1'b1, 1, 120,  1'b0};
    vec[6] = '{32'h00000007, 1'b1, 1'b1, 1, 7,    1'b0};
    vec[7] = '{32'h05050505, 1'b0, 1'b1, 0, 0,    1'b0};
    vec[8] = '{32'h01010101, 1'b0, 1'b0, 1, 24,   1'b0};
    vec[9] = '{32'h80808080, 1'b1, 1'b0, 1, 512,  1'b0};
    for (int i = 0; i < 8; i++)
      sbeat[i] = {8'(255 - i), 8'(3 * i), 8'(2 * i), 8'(i + 1)};

    rst = 1'b0;
    in_valid = 0; in_data = '0; in_last = 0; acc_mode = 0; out_ready = 1;
    b_in_valid = 0; b_in_data = '0; b_in_last = 0; b_acc_mode = 0; b_out_ready = 1;
    mon_en = 0; open_sum = 0; open_sat = 0; n_out = 0;

    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_sat", out_sat, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("post_rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Vector table: one beat each, output count, value and latency
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_data = vec[i].data; in_last = vec[i].last; acc_mode = vec[i].mode;
      #1 chk($sformatf("tbl%0d_accept", i), in_ready, 1);
      @(negedge clk);
      in_valid = 0;
      collect_a(seen, lat, s, sat);
      chk($sformatf("tbl%0d_outcount", i), seen, vec[i].nout);
      if (vec[i].nout == 1) begin
        chk($sformatf("tbl%0d_sum", i), s, vec[i].sum);
        chk($sformatf("tbl%0d_sat", i), sat, vec[i].sat);
        chk($sformatf("tbl%0d_latency", i), lat, LAT);
      end
    end

    // Back-to-back independent beats leave on consecutive cycles
    in_valid = 1; in_data = 32'hFFFFFFFF; acc_mode = 0; in_last = 0;
    @(negedge clk);
    in_data = 32'h01000000;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    #1 chk("b2b_valid0", out_valid, 1);
    chk("b2b_sum0", out_sum, 1020);
    @(negedge clk);
    #1 chk("b2b_valid1", out_valid, 1);
    chk("b2b_sum1", out_sum, 1);
    @(negedge clk);
    #1 chk("b2b_idle", out_valid, 0);
    @(negedge clk);

    // Stall mid-stream: 8 distinct beats, out_ready low for 5 cycles
    exp_q.delete(); open_sum = 0; open_sat = 0; n_out = 0; mon_en = 1;
    idx = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 9);
      in_valid  = (idx < 8);
      in_data   = sbeat[idx % 8];
      in_last   = 0;
      acc_mode  = 0;
      #1;
      if (cyc >= 5 && cyc < 9) chk($sformatf("stall_in_ready_c%0d", cyc), in_ready, 0);
      if (in_valid && in_ready) idx++;
      @(negedge clk);
    end
    in_valid = 0; out_ready = 1;
    chk("stall_accepted", idx, 8);
    chk("stall_delivered", n_out, 8);
    chk("stall_pending", exp_q.size(), 0);

    // Randomized stream with random backpressure
    n_out = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      acc_mode  = ($urandom_range(0, 2) != 0);
      in_last   = ($urandom_range(0, 3) == 0);
      #1;
      @(negedge clk);
    end
    out_ready = 1;
    in_valid = 1; in_data = $urandom; acc_mode = 0; in_last = 0;
    for (int w = 0; w < 20 && !in_ready; w++) @(negedge clk);
    @(negedge clk);
    in_valid = 0;
    repeat (8) @(negedge clk);
    chk("rand_pending", exp_q.size(), 0);
    chk("rand_some_output", (n_out > 0) ? 1 : 0, 1);
    mon_en = 0;

    // Narrow accumulator saturates, then a fresh frame starts clean
    b_in_valid = 1; b_in_data = 32'hFFFFFFFF; b_acc_mode = 1; b_in_last = 0;
    @(negedge clk);
    b_in_last = 1;
    @(negedge clk);
    b_in_valid = 0; b_in_last = 0; b_acc_mode = 0;
    collect_b(seen, lat, s, sat);
    chk("sat_outcount", seen, 1);
    chk("sat_sum", s, 1023);
    chk("sat_flag", sat, 1);
    b_in_valid = 1; b_in_data = 32'h00000001; b_acc_mode = 0;
    @(negedge clk);
    b_in_valid = 0;
    collect_b(seen, lat, s, sat);
    chk("sat_next_outcount", seen, 1);
    chk("sat_next_sum", s, 1);
    chk("sat_next_flag", sat, 0);

    // Asynchronous reset with an open frame and a pending result
    out_ready = 0; in_valid = 1; acc_mode = 0; in_last = 0; in_data = 32'h01010101;
    @(negedge clk);
    acc_mode = 1; in_data = 32'h05050505;
    @(negedge clk);
    in_data = 32'h06060606;
    @(negedge clk);
    in_valid = 0; acc_mode = 0;
    @(negedge clk);
    #1 chk("prerst_out_valid", out_valid, 1);
    #2 rst = 1'b0;
    #1 chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_sum", out_sum, 0);
    #3 rst = 1'b1;
    @(negedge clk);
    out_ready = 1; in_valid = 1; acc_mode = 0; in_data = 32'h02020202;
    #1 chk("postrst_accept", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
    collect_a(seen, lat, s, sat);
    chk("postrst_outcount", seen, 1);
    chk("postrst_sum", s, 8);
    chk("postrst_sat", sat, 0);
    chk("postrst_latency", lat, LAT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
